// File: rtl/vx_exe_route_arb_if.sv
// Bundle of request, per-unit and merged response signals for vx_exe_route_arb.
// slave is the router's view and master is the surrounding logic's view.
interface vx_exe_route_arb_if #(
  parameter int NUM_UNITS = 3,
  parameter int TYPE_BITS = 2,
  parameter int REQ_DATAW = 64,
  parameter int RSP_DATAW = 64
);
  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // Every channel is valid/ready: a transfer happens on a rising clk edge with
  // valid && ready. A source holds valid and payload stable until that edge, and
  // it never waits for ready before raising valid.
  logic                           req_valid;
  logic [TYPE_BITS-1:0]           req_type;
  logic [REQ_DATAW-1:0]           req_data;
  logic                           req_ready;
  logic [NUM_UNITS-1:0]           unit_req_valid;
  logic [NUM_UNITS*REQ_DATAW-1:0] unit_req_data;
  logic [NUM_UNITS-1:0]           unit_req_ready;
  logic [NUM_UNITS-1:0]           unit_rsp_valid;
  logic [NUM_UNITS*RSP_DATAW-1:0] unit_rsp_data;
  logic [NUM_UNITS-1:0]           unit_rsp_ready;
  logic                           rsp_valid;
  logic [RSP_DATAW-1:0]           rsp_data;
  logic [SEL_W-1:0]               rsp_sel;
  logic                           rsp_ready;
  logic                           err_illegal;
  logic                           idle;

  modport slave (
    input  req_valid, req_type, req_data, unit_req_ready, unit_rsp_valid, unit_rsp_data, rsp_ready,
    output req_ready, unit_req_valid, unit_req_data, unit_rsp_ready, rsp_valid, rsp_data, rsp_sel,
           err_illegal, idle
  );

  modport master (
    output req_valid, req_type, req_data, unit_req_ready, unit_rsp_valid, unit_rsp_data, rsp_ready,
    input  req_ready, unit_req_valid, unit_req_data, unit_rsp_ready, rsp_valid, rsp_data, rsp_sel,
           err_illegal, idle
  );
endinterface

// File: rtl/vx_exe_route_arb.sv
// Execute-stage router with per-unit credit limits and a round-robin response merger.
// Define EXE_ROUTE_PERF_EN to add the perf_req_stalls / perf_rsp_count counters.
module vx_exe_route_arb #(
  parameter int NUM_UNITS   = 3,
  parameter int TYPE_BITS   = 2,
  parameter int REQ_DATAW   = 64,
  parameter int RSP_DATAW   = 64,
  parameter int MAX_PENDING = 4,
  parameter int OUT_BUF     = 1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef EXE_ROUTE_PERF_EN
  output logic [31:0] perf_req_stalls,
  output logic [31:0] perf_rsp_count,
`endif
  vx_exe_route_arb_if.slave bus
);
  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [CNT_W-1:0]     cnt [NUM_UNITS];
  logic [NUM_UNITS-1:0] avail, req_fire, rsp_fire;
  logic                 type_legal, cnt_zero, err_q;
  logic [SEL_W-1:0]     rr_ptr, grant, lock_sel, cand;
  logic                 lock_q, found;
  logic                 arb_valid, arb_ready, arb_fire, out_valid;
  logic [RSP_DATAW-1:0] arb_data;

  assign type_legal = 32'(bus.req_type) < 32'(NUM_UNITS);

  // Illegal types are swallowed: ready stays high so the stream never wedges.
  always_comb begin
    avail              = '0;
    bus.unit_req_valid = '0;
    bus.req_ready      = !type_legal;
    for (int u = 0; u < NUM_UNITS; u++) begin
      avail[u] = cnt[u] < CNT_W'(MAX_PENDING);
      if (32'(bus.req_type) == 32'(u)) begin
        bus.unit_req_valid[u] = bus.req_valid && avail[u];
        bus.req_ready         = bus.unit_req_ready[u] && avail[u];
      end
    end
  end

  assign bus.unit_req_data = {NUM_UNITS{bus.req_data}};
  assign req_fire          = bus.unit_req_valid & bus.unit_req_ready;
  assign rsp_fire          = bus.unit_rsp_valid & bus.unit_rsp_ready;

  // A grant left unaccepted last cycle is replayed so the choice stays stable.
  always_comb begin
    grant = rr_ptr;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      grant = lock_sel;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        cand = SEL_W'((32'(rr_ptr) + 32'(i)) % 32'(NUM_UNITS));
        if (!found && bus.unit_rsp_valid[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
    arb_valid = bus.unit_rsp_valid[grant];
    arb_data  = bus.unit_rsp_data[grant*RSP_DATAW +: RSP_DATAW];
    for (int u = 0; u < NUM_UNITS; u++) begin
      bus.unit_rsp_ready[u] = arb_ready && (32'(grant) == 32'(u));
    end
  end

  assign arb_fire = arb_valid && arb_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      lock_q   <= 1'b0;
      lock_sel <= '0;
      err_q    <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) cnt[u] <= '0;
    end else begin
      lock_q   <= arb_valid && !arb_ready;
      lock_sel <= grant;
      if (arb_fire) rr_ptr <= (grant == SEL_W'(NUM_UNITS - 1)) ? '0 : grant + SEL_W'(1);
      if (bus.req_valid && !type_legal) err_q <= 1'b1;
      // Simultaneous issue and retire cancel; a stray retire at zero is ignored.
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (req_fire[u] && !rsp_fire[u]) cnt[u] <= cnt[u] + CNT_W'(1);
        else if (!req_fire[u] && rsp_fire[u] && cnt[u] != '0) cnt[u] <= cnt[u] - CNT_W'(1);
      end
    end
  end

  generate
    if (OUT_BUF != 0) begin : g_out_reg
      logic [RSP_DATAW-1:0] out_data;
      logic [SEL_W-1:0]     out_sel;
      assign arb_ready = !out_valid || bus.rsp_ready;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_sel   <= '0;
        end else if (arb_ready) begin
          out_valid <= arb_valid;
          out_data  <= arb_data;
          out_sel   <= grant;
        end
      end
      assign bus.rsp_valid = out_valid;
      assign bus.rsp_data  = out_data;
      assign bus.rsp_sel   = out_sel;
    end else begin : g_out_comb
      assign arb_ready     = bus.rsp_ready;
      assign out_valid     = 1'b0;
      assign bus.rsp_valid = arb_valid;
      assign bus.rsp_data  = arb_data;
      assign bus.rsp_sel   = grant;
    end
  endgenerate

  always_comb begin
    cnt_zero = 1'b1;
    for (int u = 0; u < NUM_UNITS; u++) if (cnt[u] != '0) cnt_zero = 1'b0;
  end

  assign bus.idle        = cnt_zero && !out_valid;
  assign bus.err_illegal = err_q;

  generate
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_chk
      a_rsp_needs_credit: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_fire[u] && cnt[u] == '0));
    end
  endgenerate

`ifdef EXE_ROUTE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_req_stalls <= '0;
      perf_rsp_count  <= '0;
    end else begin
      if (bus.req_valid && !bus.req_ready && type_legal) perf_req_stalls <= perf_req_stalls + 32'd1;
      if (bus.rsp_valid && bus.rsp_ready) perf_rsp_count <= perf_rsp_count + 32'd1;
    end
  end
`else
  // Without the perf option there is no counter state at all.
`endif
endmodule

// File: tb/tb_vx_exe_route_arb.sv
// Directed and randomized bench for vx_exe_route_arb (3 units, 4 credits, registered output).
module tb_vx_exe_route_arb;
  localparam int NU = 3;
  localparam int TW = 2;
  localparam int DW = 64;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  vx_exe_route_arb_if #(.NUM_UNITS(NU), .TYPE_BITS(TW), .REQ_DATAW(DW), .RSP_DATAW(DW)) bus ();
`ifdef EXE_ROUTE_PERF_EN
  logic [31:0] perf_req_stalls, perf_rsp_count;
`endif

  vx_exe_route_arb #(.NUM_UNITS(NU), .TYPE_BITS(TW), .REQ_DATAW(DW), .RSP_DATAW(DW),
                     .MAX_PENDING(MP), .OUT_BUF(1)) dut (
    .clk(clk),
    .reset(reset),
`ifdef EXE_ROUTE_PERF_EN
    .perf_req_stalls(perf_req_stalls),
    .perf_rsp_count(perf_rsp_count),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_type = '0; bus.req_data = '0;
    bus.unit_req_ready = '0; bus.unit_rsp_valid = '0; bus.unit_rsp_data = '0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic issue(input int t, input int n);
    bus.unit_req_ready = '1;
    bus.req_type = TW'(t);
    bus.req_valid = 1'b1;
    repeat (n) next_cycle();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (bus.idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    tests_run++; if (bus.err_illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", bus.err_illegal); end
    tests_run++; if (bus.unit_req_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_unit_req_valid: got %b want 000", bus.unit_req_valid); end
`ifdef EXE_ROUTE_PERF_EN
    tests_run++; if (perf_req_stalls !== 32'd0 || perf_rsp_count !== 32'd0) begin tests_failed++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_req_stalls, perf_rsp_count); end
`endif
  endtask

  task automatic test_credit_stall();
    do_reset();
    bus.unit_req_ready = '1; bus.req_type = 2'd1; bus.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_data = {$urandom, $urandom};
      #1;
      tests_run++; if (bus.req_ready !== 1'b1 || bus.unit_req_valid !== 3'b010) begin tests_failed++; $display("FAIL credit_accept%0d: got ready=%b uv=%b want 1/010", k, bus.req_ready, bus.unit_req_valid); end
      next_cycle();
    end
    #1;
    tests_run++; if (bus.req_ready !== 1'b0 || bus.unit_req_valid !== 3'b000) begin tests_failed++; $display("FAIL credit_full_stall: got ready=%b uv=%b want 0/000", bus.req_ready, bus.unit_req_valid); end
    bus.unit_rsp_valid = 3'b010; bus.unit_rsp_data[DW +: DW] = 64'h5151; bus.rsp_ready = 1'b1;
    #1;
    tests_run++; if (bus.unit_rsp_ready !== 3'b010 || bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL credit_retire_cycle: got urr=%b ready=%b want 010/0", bus.unit_rsp_ready, bus.req_ready); end
    next_cycle();
    bus.unit_rsp_valid = '0;
    #1;
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL credit_reopen: got %b want 1", bus.req_ready); end
    tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h5151 || bus.rsp_sel !== 2'd1) begin tests_failed++; $display("FAIL credit_rsp_out: got v=%b d=%h s=%0d want 1/5151/1", bus.rsp_valid, bus.rsp_data, bus.rsp_sel); end
    next_cycle();
    bus.req_valid = 1'b0;
    #1;
    tests_run++; if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL credit_refull: got %b want 0", bus.req_ready); end
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int u = 0; u < NU; u++) issue(u, 2);
    for (int u = 0; u < NU; u++) bus.unit_rsp_data[u*DW +: DW] = 64'hA0 + 64'(u);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      bus.unit_rsp_valid = (i < 6) ? 3'b111 : 3'b000;
      #1;
      if (i == 0) begin
        tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_fill: got %b want 0", bus.rsp_valid); end
      end else begin
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_sel !== 2'((i - 1) % 3) || bus.rsp_data !== 64'hA0 + 64'((i - 1) % 3)) begin
          tests_failed++; $display("FAIL rr_seq%0d: got v=%b s=%0d d=%h want 1/%0d", i, bus.rsp_valid, bus.rsp_sel, bus.rsp_data, (i - 1) % 3);
        end
      end
      next_cycle();
    end
    #1;
    tests_run++; if (bus.idle !== 1'b1) begin tests_failed++; $display("FAIL rr_drained_idle: got %b want 1", bus.idle); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    issue(0, 1);
    issue(2, 1);
    bus.rsp_ready = 1'b0;
    bus.unit_rsp_data[0 +: DW] = 64'h1111; bus.unit_rsp_data[2*DW +: DW] = 64'h2222;
    bus.unit_rsp_valid = 3'b101;
    #1;
    tests_run++; if (bus.unit_rsp_ready !== 3'b001) begin tests_failed++; $display("FAIL bp_first_grant: got %b want 001", bus.unit_rsp_ready); end
    next_cycle();
    bus.unit_rsp_valid = 3'b100;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sel !== 2'd0 || bus.rsp_data !== 64'h1111 || bus.unit_rsp_ready !== 3'b000) begin
        tests_failed++; $display("FAIL bp_hold%0d: got v=%b s=%0d d=%h urr=%b want 1/0/1111/000", k, bus.rsp_valid, bus.rsp_sel, bus.rsp_data, bus.unit_rsp_ready);
      end
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++; if (bus.rsp_sel !== 2'd0 || bus.unit_rsp_ready !== 3'b100) begin tests_failed++; $display("FAIL bp_release: got s=%0d urr=%b want 0/100", bus.rsp_sel, bus.unit_rsp_ready); end
    next_cycle();
    bus.unit_rsp_valid = '0;
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sel !== 2'd2 || bus.rsp_data !== 64'h2222) begin tests_failed++; $display("FAIL bp_unit2_next: got v=%b s=%0d d=%h want 1/2/2222", bus.rsp_valid, bus.rsp_sel, bus.rsp_data); end
    next_cycle();
  endtask

  task automatic test_illegal();
    do_reset();
    bus.unit_req_ready = '1; bus.req_type = 2'd3; bus.req_valid = 1'b1;
    #1;
    tests_run++; if (bus.req_ready !== 1'b1 || bus.unit_req_valid !== 3'b000 || bus.err_illegal !== 1'b0) begin tests_failed++; $display("FAIL illegal_accept: got r=%b uv=%b err=%b want 1/000/0", bus.req_ready, bus.unit_req_valid, bus.err_illegal); end
    next_cycle();
    bus.req_valid = 1'b0;
    #1;
    tests_run++; if (bus.err_illegal !== 1'b1 || bus.idle !== 1'b1) begin tests_failed++; $display("FAIL illegal_flag: got err=%b idle=%b want 1/1", bus.err_illegal, bus.idle); end
    repeat (3) next_cycle();
    tests_run++; if (bus.err_illegal !== 1'b1) begin tests_failed++; $display("FAIL illegal_sticky: got %b want 1", bus.err_illegal); end
    do_reset();
    tests_run++; if (bus.err_illegal !== 1'b0) begin tests_failed++; $display("FAIL illegal_cleared: got %b want 0", bus.err_illegal); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(0, 2);
    issue(1, 1);
    bus.rsp_ready = 1'b0;
    bus.unit_rsp_data[DW +: DW] = 64'h7777;
    bus.unit_rsp_valid = 3'b010;
    next_cycle();
    bus.unit_rsp_valid = '0;
    tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sel !== 2'd1 || bus.idle !== 1'b0) begin tests_failed++; $display("FAIL areset_pre: got v=%b s=%0d idle=%b want 1/1/0", bus.rsp_valid, bus.rsp_sel, bus.idle); end
    #2;
    reset = 1'b0;
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b0 || bus.idle !== 1'b1) begin tests_failed++; $display("FAIL areset_now: got v=%b idle=%b want 0/1", bus.rsp_valid, bus.idle); end
`ifdef EXE_ROUTE_PERF_EN
    tests_run++; if (perf_req_stalls !== 32'd0 || perf_rsp_count !== 32'd0) begin tests_failed++; $display("FAIL areset_perf: got %0d/%0d want 0/0", perf_req_stalls, perf_rsp_count); end
`endif
    do_reset();
  endtask

  task automatic test_random();
    int m_cnt[NU];
    bit u_valid[NU];
    logic [DW-1:0] u_data[NU];
    logic [DW+1:0] exp_q[$];
    int m_ptr, m_lock, m_stall, m_rsp;
    bit m_err;
    do_reset();
    for (int u = 0; u < NU; u++) begin m_cnt[u] = 0; u_valid[u] = 1'b0; u_data[u] = '0; end
    m_ptr = 0; m_lock = -1; m_stall = 0; m_rsp = 0; m_err = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit rv, rr, legal, acc_ok, any_v, idle_exp;
      int t, g;
      logic [NU-1:0] urr, exp_uv, exp_urr, vvec;
      rv = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 11) == 0) ? 3 : $urandom_range(0, NU - 1);
      urr = NU'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      for (int u = 0; u < NU; u++) begin
        if (!u_valid[u] && m_cnt[u] > 0 && $urandom_range(0, 1) == 1) begin
          u_valid[u] = 1'b1;
          u_data[u] = {8'(u), 24'(cyc), 32'($urandom)};
        end
      end
      bus.req_valid = rv; bus.req_type = TW'(t); bus.req_data = {$urandom, $urandom};
      bus.unit_req_ready = urr; bus.rsp_ready = rr;
      for (int u = 0; u < NU; u++) begin
        vvec[u] = u_valid[u];
        bus.unit_rsp_data[u*DW +: DW] = u_data[u];
      end
      bus.unit_rsp_valid = vvec;
      #1;
      legal = (t < NU);
      acc_ok = legal ? (urr[t] && m_cnt[t] < MP) : 1'b1;
      exp_uv = (rv && legal && m_cnt[t] < MP) ? NU'(1 << t) : '0;
      any_v = (vvec != '0);
      g = 0;
      if (m_lock >= 0) g = m_lock;
      else for (int k = NU - 1; k >= 0; k--) if (vvec[(m_ptr + k) % NU]) g = (m_ptr + k) % NU;
      exp_urr = (any_v && (exp_q.size() == 0 || rr)) ? NU'(1 << g) : '0;
      idle_exp = (exp_q.size() == 0);
      for (int u = 0; u < NU; u++) if (m_cnt[u] != 0) idle_exp = 1'b0;
      tests_run++; if (bus.req_ready !== acc_ok) begin tests_failed++; $display("FAIL rand_req_ready c%0d: got %b want %b", cyc, bus.req_ready, acc_ok); end
      tests_run++; if (bus.unit_req_valid !== exp_uv) begin tests_failed++; $display("FAIL rand_unit_req_valid c%0d: got %b want %b", cyc, bus.unit_req_valid, exp_uv); end
      tests_run++; if ((bus.unit_rsp_ready & vvec) !== exp_urr) begin tests_failed++; $display("FAIL rand_grant c%0d: got %b want %b", cyc, bus.unit_rsp_ready & vvec, exp_urr); end
      tests_run++; if (bus.rsp_valid !== (exp_q.size() != 0)) begin tests_failed++; $display("FAIL rand_rsp_valid c%0d: got %b want %b", cyc, bus.rsp_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        tests_run++; if ({bus.rsp_sel, bus.rsp_data} !== exp_q[0]) begin tests_failed++; $display("FAIL rand_rsp_data c%0d: got %h want %h", cyc, {bus.rsp_sel, bus.rsp_data}, exp_q[0]); end
      end
      tests_run++; if (bus.idle !== idle_exp || bus.err_illegal !== m_err) begin tests_failed++; $display("FAIL rand_idle_err c%0d: got %b%b want %b%b", cyc, bus.idle, bus.err_illegal, idle_exp, m_err); end
      if (rv && legal && !acc_ok) m_stall++;
      if (exp_q.size() != 0 && rr) begin void'(exp_q.pop_front()); m_rsp++; end
      if (any_v && exp_urr != '0) begin
        exp_q.push_back({2'(g), u_data[g]});
        u_valid[g] = 1'b0; m_cnt[g]--; m_ptr = (g + 1) % NU; m_lock = -1;
      end else m_lock = any_v ? g : -1;
      if (rv && legal && acc_ok) m_cnt[t]++;
      if (rv && !legal) m_err = 1'b1;
      next_cycle();
    end
`ifdef EXE_ROUTE_PERF_EN
    tests_run++; if (perf_req_stalls !== 32'(m_stall) || perf_rsp_count !== 32'(m_rsp)) begin tests_failed++; $display("FAIL rand_perf: got %0d/%0d want %0d/%0d", perf_req_stalls, perf_rsp_count, m_stall, m_rsp); end
`endif
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_credit_stall();
    test_rr_order();
    test_back_pressure();
    test_illegal();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
